// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker that measures VGA raster geometry
// (line length, active width, frame height, active height) from the timing bus,
// compares it with expected values, declares lock after consecutive clean frames
// and pulses an error when a locked raster deviates.
// Ports: clk/rst (sync, active-high); hsync_in/vsync_in/hblnk_in/vblnk_in timing
// inputs; h_total/h_active/v_total/v_active last measurements; frame_start pulse
// on vsync rise; locked status; timing_err pulse on loss of lock.
module vga_timing_monitor #(
   parameter int CW           = 11,
   parameter int H_TOTAL_EXP  = 1344,
   parameter int H_ACTIVE_EXP = 1024,
   parameter int V_TOTAL_EXP  = 806,
   parameter int V_ACTIVE_EXP = 768,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic          hblnk_in,
   input  logic          vblnk_in,
   output logic [CW-1:0] h_total,
   output logic [CW-1:0] h_active,
   output logic [CW-1:0] v_total,
   output logic [CW-1:0] v_active,
   output logic          frame_start,
   output logic          locked,
   output logic          timing_err
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] H_TOT   = CW'(H_TOTAL_EXP);
   localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE_EXP);
   localparam logic [CW-1:0] V_TOT   = CW'(V_TOTAL_EXP);
   localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE_EXP);
   localparam logic [3:0]    LOCK_N  = 4'(LOCK_FRAMES);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   // Input sampling stage. Deliberately not reset: it keeps sampling through
   // reset so a sync level held across reset is not mistaken for a new edge.
   // Only the syncs need a previous-value copy; blanking is used as a level.
   logic s_hs_q, s_vs_q, s_hb_q, s_vb_q;
   logic p_hs_q, p_vs_q;

   always_ff @(posedge clk) begin
      s_hs_q <= hsync_in;
      s_vs_q <= vsync_in;
      s_hb_q <= hblnk_in;
      s_vb_q <= vblnk_in;
      p_hs_q <= s_hs_q;
      p_vs_q <= s_vs_q;
   end

   logic hs_edge, vs_edge;
   assign hs_edge = s_hs_q & ~p_hs_q;
   assign vs_edge = s_vs_q & ~p_vs_q;

   logic [CW-1:0] h_cnt_q, h_cnt_d, ha_cnt_q, ha_cnt_d;
   logic [CW-1:0] ln_cnt_q, ln_cnt_d, al_cnt_q, al_cnt_d;
   logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
   logic [CW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
   logic          h_valid_q, h_valid_d, line_err_q, line_err_d;
   logic          frame_start_q, frame_start_d, locked_q, locked_d;
   logic          timing_err_q, timing_err_d;
   logic [1:0]    state_q, state_d;
   logic [3:0]    match_cnt_q, match_cnt_d;

   // Line/frame lengths including the current cycle, so a line that closes on
   // the same cycle as a vsync edge lands in the frame being closed.
   logic          h_sat;
   logic [CW-1:0] h_len, ha_len, ln_len, al_len;
   logic          line_mis, line_err_all, frame_ok, overrun;

   always_comb begin
      h_sat        = (h_cnt_q == CNT_MAX);
      h_len        = h_sat ? CNT_MAX : h_cnt_q + ONE;
      ha_len       = (!s_hb_q && ha_cnt_q != CNT_MAX) ? ha_cnt_q + ONE : ha_cnt_q;
      ln_len       = (hs_edge && ln_cnt_q != CNT_MAX) ? ln_cnt_q + ONE : ln_cnt_q;
      al_len       = (hs_edge && !s_vb_q && al_cnt_q != CNT_MAX) ? al_cnt_q + ONE : al_cnt_q;
      // A saturated line counter means the true length is unknown: never a match.
      line_mis     = hs_edge && h_valid_q && (h_sat || h_len != H_TOT || ha_len != H_ACT);
      line_err_all = line_err_q | line_mis;
      frame_ok     = (ln_len == V_TOT) && (al_len == V_ACT) && !line_err_all;
      overrun      = (ln_len > V_TOT);
   end

   always_comb begin
      h_cnt_d       = hs_edge ? '0 : (h_sat ? h_cnt_q : h_cnt_q + ONE);
      ha_cnt_d      = hs_edge ? '0 : ha_len;
      h_total_d     = hs_edge ? h_len  : h_total_q;
      h_active_d    = hs_edge ? ha_len : h_active_q;
      h_valid_d     = h_valid_q | hs_edge;
      ln_cnt_d      = vs_edge ? '0 : ln_len;
      al_cnt_d      = vs_edge ? '0 : al_len;
      v_total_d     = vs_edge ? ln_len : v_total_q;
      v_active_d    = vs_edge ? al_len : v_active_q;
      frame_start_d = vs_edge;
      line_err_d    = vs_edge ? 1'b0 : line_err_all;

      state_d       = state_q;
      match_cnt_d   = match_cnt_q;
      locked_d      = locked_q;
      timing_err_d  = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (vs_edge) begin
               state_d     = ST_MEASURE;
               match_cnt_d = '0;
            end
         end
         ST_MEASURE: begin
            if (vs_edge) begin
               if (frame_ok) begin
                  match_cnt_d = match_cnt_q + 4'd1;
                  if (match_cnt_q + 4'd1 == LOCK_N) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
         end
         ST_LOCKED: begin
            // Leaving LOCKED on the first fault guarantees a single error pulse.
            if (line_mis || (vs_edge && !frame_ok) || overrun) begin
               timing_err_d = 1'b1;
               locked_d     = 1'b0;
               state_d      = ST_MEASURE;
               match_cnt_d  = '0;
            end
         end
         default: begin
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q       <= '0;
         ha_cnt_q      <= '0;
         ln_cnt_q      <= '0;
         al_cnt_q      <= '0;
         h_total_q     <= '0;
         h_active_q    <= '0;
         v_total_q     <= '0;
         v_active_q    <= '0;
         h_valid_q     <= 1'b0;
         line_err_q    <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         timing_err_q  <= 1'b0;
         state_q       <= ST_SEARCH;
         match_cnt_q   <= '0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         ha_cnt_q      <= ha_cnt_d;
         ln_cnt_q      <= ln_cnt_d;
         al_cnt_q      <= al_cnt_d;
         h_total_q     <= h_total_d;
         h_active_q    <= h_active_d;
         v_total_q     <= v_total_d;
         v_active_q    <= v_active_d;
         h_valid_q     <= h_valid_d;
         line_err_q    <= line_err_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         timing_err_q  <= timing_err_d;
         state_q       <= state_d;
         match_cnt_q   <= match_cnt_d;
      end
   end

   assign h_total     = h_total_q;
   assign h_active    = h_active_q;
   assign v_total     = v_total_q;
   assign v_active    = v_active_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: drives a scaled-down raster (20 clk lines, 10-line
// frames) with directed faults and random jitter, and compares every output
// each cycle against a line/frame-record reference model.
module tb_vga_timing_monitor;

   localparam int CW       = 8;
   localparam int MAXV     = 255;
   localparam int H_TOT    = 20;
   localparam int H_ACT    = 14;
   localparam int V_TOT    = 10;
   localparam int V_ACT    = 8;
   localparam int LOCK     = 2;
   localparam int HS_START = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [CW-1:0] h_total, h_active, v_total, v_active;
   logic          frame_start, locked, timing_err;

   vga_timing_monitor #(
      .CW(CW), .H_TOTAL_EXP(H_TOT), .H_ACTIVE_EXP(H_ACT),
      .V_TOTAL_EXP(V_TOT), .V_ACTIVE_EXP(V_ACT), .LOCK_FRAMES(LOCK)
   ) dut (
      .clk(clk), .rst(rst),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
      .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_SEARCH, M_MEASURE, M_LOCKED} mstate_t;
   typedef struct { bit blank; bit bad; } line_rec_t;

   logic [3:0] in_d1 = '0, in_d2 = '0;   // {hs,vs,hb,vb} driven one and two cycles ago
   bit         line_hb[$];               // sampled hblnk of each cycle of the open line
   line_rec_t  frame_lines_q[$];         // lines closed since the last vsync edge
   bit         seen_line;
   mstate_t    mst;
   int         mcnt;
   int m_ht, m_ha, m_vt, m_va, m_fs, m_lk, m_err;

   task automatic model_step(input bit r, input logic [3:0] cur);
      bit hs_e, vs_e, line_bad, good, bad_any;
      int n, zeros, act;
      hs_e = in_d1[3] & ~in_d2[3];
      vs_e = in_d1[2] & ~in_d2[2];
      if (r) begin
         m_ht = 0; m_ha = 0; m_vt = 0; m_va = 0; m_fs = 0; m_lk = 0; m_err = 0;
         line_hb.delete(); frame_lines_q.delete();
         seen_line = 0; mst = M_SEARCH; mcnt = 0;
      end else begin
         m_fs = 0; m_err = 0; line_bad = 0; good = 0;
         line_hb.push_back(in_d1[1]);
         if (hs_e) begin
            n = line_hb.size();
            zeros = 0;
            foreach (line_hb[i]) if (!line_hb[i]) zeros++;
            m_ht = (n > MAXV) ? MAXV : n;
            act  = (zeros > MAXV) ? MAXV : zeros;
            m_ha = act;
            if (seen_line) line_bad = (n > MAXV) || (m_ht != H_TOT) || (act != H_ACT);
            seen_line = 1;
            frame_lines_q.push_back('{blank: in_d1[0], bad: line_bad});
            line_hb.delete();
         end
         n = frame_lines_q.size();
         if (vs_e) begin
            act = 0; bad_any = 0;
            foreach (frame_lines_q[i]) begin
               if (!frame_lines_q[i].blank) act++;
               if (frame_lines_q[i].bad) bad_any = 1;
            end
            m_vt = n; m_va = act; m_fs = 1;
            good = (n == V_TOT) && (act == V_ACT) && !bad_any;
            frame_lines_q.delete();
         end
         case (mst)
            M_SEARCH:  if (vs_e) begin mst = M_MEASURE; mcnt = 0; end
            M_MEASURE: if (vs_e) begin
               if (good) begin
                  mcnt++;
                  if (mcnt == LOCK) begin mst = M_LOCKED; m_lk = 1; end
               end else mcnt = 0;
            end
            default: if (line_bad || (vs_e && !good) || n > V_TOT) begin
               m_err = 1; m_lk = 0; mst = M_MEASURE; mcnt = 0;
            end
         endcase
      end
      in_d2 = in_d1;
      in_d1 = cur;
   endtask

   // ---------------- raster generator ----------------
   int hpos = 0, vpos = 0, line_len = H_TOT, line_act = H_ACT, frame_len = V_TOT, hs0 = 0;
   bit frozen = 0, short_frame = 0, rnd_align = 0;
   int stretch_line = -1, rnd_h = 0, rnd_v = 0;

   task automatic advance();
      hpos++;
      if (hpos >= line_len) begin
         hpos = 0;
         vpos++;
         if (vpos >= frame_len) begin
            vpos = 0;
            frame_len = V_TOT;
            if (short_frame) begin frame_len = V_TOT - 1; short_frame = 0; end
            else if (rnd_v > 0 && $urandom_range(99) < rnd_v) frame_len = $urandom_range(V_TOT+1, V_TOT-1);
         end
         line_len = H_TOT;
         line_act = H_ACT;
         if (vpos == stretch_line) begin line_len = H_TOT + 1; stretch_line = -1; end
         else if (rnd_h > 0 && $urandom_range(99) < rnd_h) begin
            line_len = $urandom_range(H_TOT+1, H_TOT-1);
            line_act = $urandom_range(H_ACT+1, H_ACT-1);
         end
         if (rnd_align && vpos == 4) hs0 = $urandom_range(1) ? HS_START : 0;
      end
   endtask

   task automatic tick(input bit r);
      logic [3:0] cur;
      cur[3] = (hpos >= HS_START) && (hpos < HS_START + 2);
      cur[2] = (vpos == frame_len - 1 && hpos >= hs0) || (vpos == 0 && hpos < hs0);
      cur[1] = (hpos >= line_act);
      cur[0] = (vpos >= V_ACT);
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = cur;
      rst = r;
      @(posedge clk);
      model_step(r, cur);
      if (!frozen) advance();
      @(negedge clk);
      check("h_total",     h_total,     m_ht);
      check("h_active",    h_active,    m_ha);
      check("v_total",     v_total,     m_vt);
      check("v_active",    v_active,    m_va);
      check("frame_start", frame_start, m_fs);
      check("locked",      locked,      m_lk);
      check("timing_err",  timing_err,  m_err);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic seek(input int v, input int h);
      for (int i = 0; i < 1000 && !(vpos == v && hpos == h); i++) tick(1'b0);
   endtask

   initial begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) tick(1'b1);
      check("rst_h_total", h_total, 0);
      check("rst_locked",  locked,  0);

      // clean raster: lock and nominal geometry
      run(1000);
      check("lock_initial", locked,   1);
      check("nom_h_total",  h_total,  H_TOT);
      check("nom_h_active", h_active, H_ACT);
      check("nom_v_total",  v_total,  V_TOT);
      check("nom_v_active", v_active, V_ACT);

      // one stretched line
      stretch_line = 5;
      run(1000);
      check("relock_stretch", locked, 1);

      // one short frame
      short_frame = 1;
      run(1000);
      check("relock_short", locked, 1);

      // hsync stalled long enough to saturate the line counter
      seek(3, 0);
      frozen = 1;
      run(300);
      frozen = 0;
      run(25);
      check("sat_h_total", h_total, MAXV);
      check("sat_unlock",  locked,  0);
      run(800);
      check("relock_sat", locked, 1);

      // one-cycle reset mid-frame
      seek(4, 5);
      tick(1'b1);
      check("midrst_h_total", h_total, 0);
      check("midrst_locked",  locked,  0);
      run(1000);
      check("relock_rst", locked, 1);

      // hsync and vsync rising on the same cycle
      seek(4, 0);
      hs0 = HS_START;
      run(800);
      check("aligned_v_total", v_total, V_TOT);
      check("aligned_locked",  locked,  1);

      // random jitter on line length, active width, frame height and alignment
      rnd_h = 4; rnd_v = 25; rnd_align = 1;
      run(6000);
      rnd_h = 0; rnd_v = 0; rnd_align = 0;
      run(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
